// File: rtl/img_frame_loader.sv
// Assembles MSB-first camera byte frames into per-junction image holding registers; one COMMIT cycle per frame.
// Optional trailing mod-256 checksum byte per frame when FRAME_CHKSUM_EN is defined.
module img_frame_loader #(
    parameter int FRAME_BITS = 3072,
    parameter int BYTE_W     = 8,
    parameter int NUM_JUNC   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [2:0]            in_sel,
    output logic [FRAME_BITS-1:0] img_mid,
    output logic [FRAME_BITS-1:0] img_l,
    output logic [FRAME_BITS-1:0] img_r,
    output logic [FRAME_BITS-1:0] img_t,
    output logic [FRAME_BITS-1:0] img_d,
    output logic [NUM_JUNC-1:0]   frame_upd,
    output logic                  err_sel,
    output logic                  err_len,
    output logic                  err_chk,
    output logic                  busy
);
    localparam int L     = FRAME_BITS / BYTE_W;
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] LEN     = CNT_W'(L);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(L - 1);
    localparam logic [2:0]       MAX_SEL = 3'(NUM_JUNC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            sel_q, sel_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] img_q [NUM_JUNC];
    logic [FRAME_BITS-1:0] img_d_n [NUM_JUNC];
    logic [NUM_JUNC-1:0]   upd_q, upd_d;
    logic                  err_sel_q, err_sel_d;
    logic                  err_len_q, err_len_d;
    logic                  accept;
    logic                  start;
`ifdef FRAME_CHKSUM_EN
    logic [BYTE_W-1:0]     sum_q, sum_d;
    logic                  err_chk_q, err_chk_d;
`endif

    assign in_ready = (state_q != ST_COMMIT);
    assign accept   = in_valid && in_ready;
    // An SOF at count == L (checksum position) is treated as the checksum byte, not a restart.
    assign start    = accept && in_sof && ((state_q != ST_FILL) || (cnt_q < LEN));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        shift_d   = shift_q;
        img_d_n   = img_q;
        upd_d     = '0;
        err_sel_d = 1'b0;
        err_len_d = 1'b0;
`ifdef FRAME_CHKSUM_EN
        sum_d     = sum_q;
        err_chk_d = 1'b0;
`endif
        if (start) begin
            err_len_d = (state_q == ST_FILL);
            if (in_sel <= MAX_SEL) begin
                sel_d   = in_sel;
                shift_d = {shift_q[FRAME_BITS-BYTE_W-1:0], in_data};
                cnt_d   = CNT_W'(1);
                state_d = ST_FILL;
`ifdef FRAME_CHKSUM_EN
                sum_d   = in_data;
`endif
            end else begin
                err_sel_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_DROP;
            end
        end else if (accept && (state_q == ST_FILL)) begin
`ifdef FRAME_CHKSUM_EN
            if (cnt_q == LEN) begin
                cnt_d     = '0;
                err_chk_d = (in_data != sum_q);
                state_d   = (in_data == sum_q) ? ST_COMMIT : ST_IDLE;
            end else begin
                shift_d = {shift_q[FRAME_BITS-BYTE_W-1:0], in_data};
                cnt_d   = cnt_q + 1'b1;
                sum_d   = sum_q + in_data;
            end
`else
            shift_d = {shift_q[FRAME_BITS-BYTE_W-1:0], in_data};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_COMMIT;
            end
`endif
        end else if (state_q == ST_COMMIT) begin
            for (int j = 0; j < NUM_JUNC; j++) begin
                if (sel_q == 3'(j)) begin
                    img_d_n[j] = shift_q;
                    upd_d[j]   = 1'b1;
                end
            end
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            shift_q   <= '0;
            upd_q     <= '0;
            err_sel_q <= 1'b0;
            err_len_q <= 1'b0;
            for (int j = 0; j < NUM_JUNC; j++) begin
                img_q[j] <= '0;
            end
`ifdef FRAME_CHKSUM_EN
            sum_q     <= '0;
            err_chk_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            shift_q   <= shift_d;
            upd_q     <= upd_d;
            err_sel_q <= err_sel_d;
            err_len_q <= err_len_d;
            for (int j = 0; j < NUM_JUNC; j++) begin
                img_q[j] <= img_d_n[j];
            end
`ifdef FRAME_CHKSUM_EN
            sum_q     <= sum_d;
            err_chk_q <= err_chk_d;
`endif
        end
    end

    assign img_mid   = img_q[0];
    assign img_l     = img_q[1];
    assign img_r     = img_q[2];
    assign img_t     = img_q[3];
    assign img_d     = img_q[4];
    assign frame_upd = upd_q;
    assign err_sel   = err_sel_q;
    assign err_len   = err_len_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef FRAME_CHKSUM_EN
    assign err_chk   = err_chk_q;
`else
    assign err_chk   = 1'b0;
`endif

endmodule

// File: tb/tb_img_frame_loader.sv
// Bench for img_frame_loader: random and directed frames against a byte-list frame model.
module tb_img_frame_loader;
    localparam int FB = 3072;
    localparam int L  = 384;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [2:0]    in_sel;
    logic [FB-1:0] img_mid, img_l, img_r, img_t, img_d;
    logic [4:0]    frame_upd;
    logic          err_sel, err_len, err_chk, busy;

    always #5 clk = ~clk;

    img_frame_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_sel(in_sel), .img_mid(img_mid), .img_l(img_l), .img_r(img_r),
        .img_t(img_t), .img_d(img_d), .frame_upd(frame_upd), .err_sel(err_sel),
        .err_len(err_len), .err_chk(err_chk), .busy(busy)
    );

    logic [FB-1:0] img_w [5];
    assign img_w[0] = img_mid;
    assign img_w[1] = img_l;
    assign img_w[2] = img_r;
    assign img_w[3] = img_t;
    assign img_w[4] = img_d;

    int n_checks = 0;
    int n_pass   = 0;

    logic [FB-1:0] exp_img [5];
    logic [7:0]    frame_buf [L];
    logic [4:0]    exp_upd [$];
    logic [4:0]    seen_upd [$];
    int            upd_base = 0;
    int e_sel = 0, e_len = 0, e_chk = 0, e_rdy = 0;
    int m_sel = 0, m_len = 0, m_chk = 0, m_rdy = 0;

    function automatic logic [63:0] fold(input logic [FB-1:0] v);
        logic [63:0] f = '0;
        for (int i = 0; i < FB / 64; i++) f = f ^ v[i*64 +: 64];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got fold=%h low=%h, expected fold=%h low=%h",
                      tag, fold(act), act[31:0], fold(exp), exp[31:0]);
    endtask

    // Byte i of a frame occupies bits [FB-1-8i -: 8].
    function automatic logic [FB-1:0] pack_frame();
        logic [FB-1:0] v = '0;
        for (int i = 0; i < L; i++) v[FB-1-8*i -: 8] = frame_buf[i];
        return v;
    endfunction

    task automatic expect_load(input int sel);
        exp_img[sel] = pack_frame();
        exp_upd.push_back(5'(1 << sel));
        e_rdy++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_upd != 5'd0) seen_upd.push_back(frame_upd);
            if (err_sel) m_sel++;
            if (err_len) m_len++;
            if (err_chk) m_chk++;
            if (!in_ready) m_rdy++;
        end
    end

    task automatic put_byte(input logic [7:0] d, input logic sof, input logic [2:0] sel, input bit gaps);
        bit done = 1'b0;
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = d; in_sof = sof; in_sel = sel;
        for (int t = 0; t < 8 && !done; t++) begin
            bit rdy;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [2:0] sel, input int n, input bit gaps);
        for (int i = 0; i < n; i++) put_byte(frame_buf[i], (i == 0), sel, gaps);
`ifdef FRAME_CHKSUM_EN
        if (n == L) begin
            logic [7:0] s = 8'd0;
            for (int i = 0; i < L; i++) s = s + frame_buf[i];
            put_byte(s, 1'b0, sel, gaps);
        end
`endif
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic fill_const(input logic [7:0] b);
        for (int i = 0; i < L; i++) frame_buf[i] = b;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < L; i++) frame_buf[i] = 8'($urandom);
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < 5; j++) chk($sformatf("%s_img%0d", tag, j), img_w[j], exp_img[j]);
        chk({tag, "_nupd"}, seen_upd.size(), exp_upd.size());
        for (int i = upd_base; i < exp_upd.size(); i++)
            chk($sformatf("%s_upd%0d", tag, i),
                (i < seen_upd.size()) ? FB'(seen_upd[i]) : {FB{1'bx}}, FB'(exp_upd[i]));
        upd_base = exp_upd.size();
        chk({tag, "_err_sel"}, m_sel, e_sel);
        chk({tag, "_err_len"}, m_len, e_len);
        chk({tag, "_err_chk"}, m_chk, e_chk);
        chk({tag, "_rdy_low"}, m_rdy, e_rdy);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_sof = 1'b0; in_sel = 3'd0;
        for (int j = 0; j < 5; j++) exp_img[j] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_upd", frame_upd, 0);
        chk("rst_errs", {err_sel, err_len, err_chk}, 0);
        check_all("rst");

        // First frame: 0xA5 then zeros, with latency checks around the commit cycle.
        fill_const(8'h00);
        frame_buf[0] = 8'hA5;
        send_frame(3'd0, L, 1'b0);
        #1;
        chk("t1_commit_upd", frame_upd, 0);
        chk("t1_commit_rdy", in_ready, 0);
        chk("t1_commit_busy", busy, 1);
        @(posedge clk); #1;
        expect_load(0);
        chk("t1_upd", frame_upd, 5'b00001);
        chk("t1_mid_top", img_mid[FB-1 -: 8], 8'hA5);
        chk("t1_mid", img_mid, exp_img[0]);
        @(posedge clk); #1;
        chk("t1_upd_gone", frame_upd, 0);
        idle(2);
        check_all("t1");

        // Back-to-back L then D, in_valid held through the commit cycle.
        fill_const(8'hFF);
        send_frame(3'd1, L, 1'b0);
        expect_load(1);
        fill_const(8'h0F);
        send_frame(3'd4, L, 1'b0);
        expect_load(4);
        idle(3);
        check_all("t2");

        // Invalid junction select: dropped.
        fill_rand();
        send_frame(3'd6, L, 1'b1);
        e_sel++;
        idle(3);
        check_all("t3");

        // Early SOF aborts the R frame; T frame loads.
        fill_rand();
        send_frame(3'd2, 100, 1'b1);
        e_len++;
        fill_rand();
        send_frame(3'd3, L, 1'b1);
        expect_load(3);
        idle(3);
        check_all("t4");

        // Reset in the middle of a Mid frame.
        fill_rand();
        send_frame(3'd0, 200, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) exp_img[j] = '0;
        chk("t5_busy", busy, 0);
        chk("t5_mid", img_mid, 0);
        @(negedge clk);
        rst = 1'b0;
        fill_rand();
        send_frame(3'd0, L, 1'b1);
        expect_load(0);
        idle(3);
        check_all("t5");

`ifdef FRAME_CHKSUM_EN
        fill_const(8'h01);
        send_frame(3'd0, L, 1'b0);
        expect_load(0);
        idle(2);
        fill_const(8'h02);
        for (int i = 0; i < L; i++) put_byte(frame_buf[i], (i == 0), 3'd0, 1'b0);
        put_byte(8'h81, 1'b0, 3'd0, 1'b0);
        e_chk++;
        idle(3);
        check_all("tchk");
`endif

        for (int it = 0; it < 8; it++) begin
            int mode;
            int nj;
            nj = $urandom_range(0, 3);
            for (int k = 0; k < nj; k++) put_byte(8'($urandom), 1'b0, 3'($urandom), 1'b1);
            mode = $urandom_range(0, 3);
            if (mode == 2) begin
                fill_rand();
                send_frame(3'($urandom_range(5, 7)), L, 1'b1);
                e_sel++;
            end else begin
                int sel;
                if (mode == 3) begin
                    fill_rand();
                    send_frame(3'($urandom_range(0, 4)), $urandom_range(1, L - 1), 1'b1);
                    e_len++;
                end
                sel = $urandom_range(0, 4);
                fill_rand();
                send_frame(3'(sel), L, 1'b1);
                expect_load(sel);
            end
            idle(3);
            check_all($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/img_frame_loader.md
# img_frame_loader

- Upstream feeder for the five `TrafficSignal` junction stages (Mid, L, R, T, D).
- Accepts a byte stream of camera frames over a valid/ready handshake and assembles each frame into the 3072-bit image vector.
- Writes the assembled frame into the holding register of the selected junction and pulses that junction's update strobe.
- Each holding register drives one `TrafficSignal` `imgData` input directly, replacing file-driven frame loading.

## Interface

Parameters:
- `FRAME_BITS`, 3072: bits per frame; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: stream word width.
- `NUM_JUNC`, 5: number of junctions. Index map: 0 = Mid, 1 = L, 2 = R, 3 = T, 4 = D.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 8: frame byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the loader accepts a byte this cycle.
- `in_sof` in 1: marks the accepted byte as the first byte of a frame; only meaningful with `in_valid`.
- `in_sel` in 3: target junction; sampled only on an SOF byte.
- `img_mid`, `img_l`, `img_r`, `img_t`, `img_d` out 3072 each: junction holding registers.
- `frame_upd` out 5: one-cycle pulse; bit *j* means holding register *j* was loaded.
- `err_sel` out 1: one-cycle pulse on an SOF byte with `in_sel` > 4.
- `err_len` out 1: one-cycle pulse when a frame is aborted by an early SOF.
- `err_chk` out 1: one-cycle pulse on a checksum mismatch (see Configuration).
- `busy` out 1: high while the state is not IDLE.

## Operation

- A byte is accepted when `in_valid` and `in_ready` are both high on a rising edge.
- Frame length L = `FRAME_BITS` / `BYTE_W` = 384 data bytes.
- Byte order is MSB first: byte 0 lands in bits [3071:3064], byte 383 in bits [7:0].
- Assembly uses a 3072-bit shift register plus a 9-bit byte counter.
- States:
  - IDLE: `in_ready` = 1. Non-SOF bytes are accepted and discarded. An SOF byte with `in_sel` ≤ 4 latches the selection, stores byte 0, sets count = 1 and moves to FILL. An SOF byte with `in_sel` > 4 pulses `err_sel` and moves to DROP.
  - FILL: `in_ready` = 1. Each accepted byte shifts in and increments count. The accept that brings count to L moves to COMMIT.
  - DROP: `in_ready` = 1. Bytes are discarded until the next SOF byte, which is then handled exactly as in IDLE.
  - COMMIT: lasts one cycle with `in_ready` = 0. The selected holding register loads the assembled frame, `frame_upd[sel]` pulses, and the state returns to IDLE.
- An SOF byte accepted in FILL at count < L:
  - pulses `err_len`;
  - discards the partial frame, leaving holding registers unchanged;
  - restarts assembly with that byte as byte 0 and the newly sampled `in_sel`, with the same validity check as IDLE.
- Holding registers change only in COMMIT; the other four junction registers hold their values.
- Two consecutive frames to the same junction overwrite in arrival order.

## Timing

- Reset value for all outputs:
  - `img_*` = 0, `frame_upd` = 0, all `err_*` = 0, `busy` = 0.
  - `in_ready` = 1 in the first cycle after reset is released; state = IDLE, count = 0.
- Reset asserted mid-frame aborts the frame without pulsing `frame_upd` and clears all holding registers.
- Latency: if the last data byte is accepted at edge k, the holding register and the `frame_upd` bit are visible after edge k+1. `frame_upd` is high for exactly that one cycle.
- `in_ready` is low only during the COMMIT cycle, giving a throughput of L accepted bytes + 1 cycle per frame.
- An `in_valid` byte presented during COMMIT is not accepted; the source must hold it until it is.
- Error pulses are registered and appear the cycle after the offending accept.

## Configuration

- `FRAME_CHKSUM_EN` defined:
  - Each frame carries one extra trailing byte at index L, equal to the mod-256 sum of data bytes 0..L-1.
  - FILL accepts L+1 bytes. The checksum byte is not shifted into the frame.
  - On match, the frame proceeds to COMMIT as normal.
  - On mismatch, `err_chk` pulses, the frame is discarded, no `frame_upd` is generated, and the state returns to IDLE with no COMMIT cycle.
- `FRAME_CHKSUM_EN` undefined: frames are L bytes and `err_chk` is tied to 0.

## Test plan

- Reset, then a frame to `in_sel` = 0 of bytes 0xA5 followed by 383 × 0x00: after the last accept + 1 edge, `img_mid[3071:3064]` = 0xA5, the rest of `img_mid` = 0, `frame_upd` = 5'b00001 for one cycle, and the other `img_*` remain 0.
- Back-to-back frames to L (all 0xFF) then D (all 0x0F) with `in_valid` held high: `in_ready` drops for exactly one cycle after each frame; `img_l` = all ones; `img_d` = repeated 0x0F; `frame_upd` pulses 5'b00010 then 5'b10000.
- SOF with `in_sel` = 6 followed by 383 bytes: `err_sel` pulses once, no `frame_upd`, and all `img_*` are unchanged.
- SOF to R, 100 bytes, then a new SOF to T with 384 bytes: `err_len` pulses once, `img_r` is unchanged, `img_t` is loaded, and `frame_upd` = 5'b01000.
- `rst` asserted at byte 200 of a Mid frame: `busy` = 0 and `img_mid` = 0 after the edge; a following full frame loads normally.
- With `FRAME_CHKSUM_EN`: 384 × 0x01 with checksum 0x80 loads the frame; the same frame with checksum 0x81 gives an `err_chk` pulse and no `frame_upd`.
